tdm_frame_master: RTL and testbench

Bus-master end of the c4/f0 TDM serial link: generates the c4 bit clock and f0 frame sync from clk50, and serializes one 32-bit word per frame onto the slave's input line, LSB first. It deserializes the slave's returned bit stream into a receive buffer. A buffer of NUM_WORDS words is cycled frame by frame, and a one-cycle buffer interrupt is raised when the last word's frame completes. The block sits on the DT side of the link, facing a slave converter that samples on c4 rising edges and resets its bit counter while f0 is low.

---
 rtl/tdm_frame_master_if.sv | 20 ++
 rtl/tdm_frame_master.sv | 178 +++++++++++++++++
 tb/tb_tdm_frame_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdm_frame_master_if.sv
// Host-side buffer port of the TDM frame master: TX word writes and RX word reads.
interface tdm_frame_master_if #(
  parameter int AW = 3
);
  logic          tx_wr_en;
  logic [AW-1:0] tx_wr_addr;
  logic [31:0]   tx_wr_data;
  logic [AW-1:0] rx_rd_addr;
  logic [31:0]   rx_rd_data;

  modport master (
    output tx_wr_en, tx_wr_addr, tx_wr_data, rx_rd_addr,
    input  rx_rd_data
  );

  modport slave (
    input  tx_wr_en, tx_wr_addr, tx_wr_data, rx_rd_addr,
    output rx_rd_data
  );
endinterface

// File: rtl/tdm_frame_master.sv
// Master end of the c4/f0 TDM link: generates c4/f0, shifts one TX word out per
// 65-slot frame (LSB first) and collects the returned word into the RX buffer.
module tdm_frame_master #(
  parameter int C4_HALF   = 6,
  parameter int NUM_WORDS = 8
) (
  input  logic                         clk50,
  input  logic                         reset,
  input  logic                         enable,
  tdm_frame_master_if.slave            host,
  output logic                         c4,
  output logic                         f0,
  output logic                         dt_tx,
  input  logic                         dt_rx,
  output logic                         busy,
  output logic [$clog2(NUM_WORDS)-1:0] frame_idx,
  output logic                         frame_done,
  output logic                         buf_int
);
  localparam int AW       = $clog2(NUM_WORDS);
  localparam int SLOT_LEN = 2 * C4_HALF;
  localparam int CW       = $clog2(SLOT_LEN);

  localparam logic [CW-1:0] CYC_LAST = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] CYC_PRE  = CW'(SLOT_LEN - 2);
  localparam logic [CW-1:0] CYC_RISE = CW'(C4_HALF);
  localparam logic [CW-1:0] CYC_SAMP = CW'(C4_HALF - 1);
  localparam logic [6:0]    LAST_SLOT = 7'd64;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [6:0]    slot_q, slot_d;
  logic [AW-1:0] frame_idx_q, frame_idx_d;
  logic [31:0]   tx_shift_q, tx_shift_d;
  logic [31:0]   rx_shift_q, rx_shift_d;
  logic          c4_q, c4_d;
  logic          f0_q, f0_d;
  logic          dt_tx_q, dt_tx_d;
  logic          frame_done_q, frame_done_d;
  logic          buf_int_q, buf_int_d;
  logic [31:0]   rx_rd_data_q, rx_rd_data_d;
  logic          slot_start;
  logic          rx_commit;

  logic [31:0] tx_mem [NUM_WORDS];
  logic [31:0] rx_mem [NUM_WORDS];

  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    slot_d       = slot_q;
    frame_idx_d  = frame_idx_q;
    tx_shift_d   = tx_shift_q;
    rx_shift_d   = rx_shift_q;
    c4_d         = 1'b0;
    f0_d         = 1'b0;
    dt_tx_d      = dt_tx_q;
    frame_done_d = 1'b0;
    buf_int_d    = 1'b0;
    rx_commit    = 1'b0;
    slot_start   = 1'b0;
    rx_rd_data_d = rx_mem[host.rx_rd_addr];

    unique case (state_q)
      IDLE: begin
        frame_idx_d = '0;
        if (enable) begin
          state_d    = RUN;
          cyc_d      = '0;
          slot_d     = '0;
          slot_start = 1'b1;
        end
      end
      RUN: begin
        if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (slot_q == LAST_SLOT) begin
            slot_d      = '0;
            frame_idx_d = frame_idx_q + 1'b1;
            if (enable) begin
              slot_start = 1'b1;
            end else begin
              state_d     = IDLE;
              frame_idx_d = '0;
            end
          end else begin
            slot_d     = slot_q + 7'd1;
            slot_start = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end

        // Returned bit k is taken at the c4 rise of even slot 2k+2.
        if ((cyc_q == CYC_SAMP) && (slot_q >= 7'd2) && !slot_q[0]) begin
          rx_shift_d = {dt_rx, rx_shift_q[31:1]};
        end

        if ((cyc_q == CYC_PRE) && (slot_q == LAST_SLOT)) begin
          frame_done_d = 1'b1;
          buf_int_d    = (frame_idx_q == LAST_IDX);
          rx_commit    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Guard slot reloads the shifter; each odd slot presents the next bit for two slots.
    if (slot_start) begin
      if (slot_d == 7'd0) begin
        tx_shift_d = tx_mem[frame_idx_d];
        dt_tx_d    = 1'b0;
      end else if (slot_d[0]) begin
        dt_tx_d    = tx_shift_q[0];
        tx_shift_d = {1'b0, tx_shift_q[31:1]};
      end
    end

    if (state_d == RUN) begin
      c4_d = (cyc_d >= CYC_RISE);
      f0_d = (slot_d != 7'd0);
    end else begin
      dt_tx_d = 1'b0;
    end
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      slot_q       <= '0;
      frame_idx_q  <= '0;
      tx_shift_q   <= '0;
      rx_shift_q   <= '0;
      c4_q         <= 1'b0;
      f0_q         <= 1'b0;
      dt_tx_q      <= 1'b0;
      frame_done_q <= 1'b0;
      buf_int_q    <= 1'b0;
      rx_rd_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      slot_q       <= slot_d;
      frame_idx_q  <= frame_idx_d;
      tx_shift_q   <= tx_shift_d;
      rx_shift_q   <= rx_shift_d;
      c4_q         <= c4_d;
      f0_q         <= f0_d;
      dt_tx_q      <= dt_tx_d;
      frame_done_q <= frame_done_d;
      buf_int_q    <= buf_int_d;
      rx_rd_data_q <= rx_rd_data_d;
    end
  end

  // Buffers are deliberately not cleared by reset.
  always_ff @(posedge clk50) begin
    if (host.tx_wr_en) begin
      tx_mem[host.tx_wr_addr] <= host.tx_wr_data;
    end
    if (rx_commit && !reset) begin
      rx_mem[frame_idx_q] <= rx_shift_q;
    end
  end

  assign c4              = c4_q;
  assign f0              = f0_q;
  assign dt_tx           = dt_tx_q;
  assign busy            = (state_q == RUN);
  assign frame_idx       = frame_idx_q;
  assign frame_done      = frame_done_q;
  assign buf_int         = buf_int_q;
  assign host.rx_rd_data = rx_rd_data_q;
endmodule

// File: tb/tb_tdm_frame_master.sv
// Scoreboard bench for tdm_frame_master with a c4-driven slave model and loopback option.
module tb_tdm_frame_master;
  localparam int C4_HALF   = 6;
  localparam int NUM_WORDS = 8;
  localparam int AW        = 3;
  localparam int SLOT_LEN  = 2 * C4_HALF;
  localparam int FRAME_LEN = 65 * SLOT_LEN;

  logic          clk50;
  logic          reset;
  logic          enable;
  logic          c4, f0, dt_tx, dt_rx;
  logic          busy;
  logic [AW-1:0] frame_idx;
  logic          frame_done, buf_int;
  logic          loopback;
  logic          slave_rx;

  int checks;
  int errors;
  int done_cnt;
  int int_cnt;
  int cyc_cnt;
  int last_done_cyc;
  int prev_done_cyc;

  logic [31:0] tx_model [NUM_WORDS];
  logic [31:0] exp_tx [$];
  int          exp_frame [$];

  int unsigned slv_cnt;
  logic [31:0] slv_word;

  tdm_frame_master_if #(.AW(AW)) bus ();

  tdm_frame_master #(.C4_HALF(C4_HALF), .NUM_WORDS(NUM_WORDS)) dut (
    .clk50      (clk50),
    .reset      (reset),
    .enable     (enable),
    .host       (bus),
    .c4         (c4),
    .f0         (f0),
    .dt_tx      (dt_tx),
    .dt_rx      (dt_rx),
    .busy       (busy),
    .frame_idx  (frame_idx),
    .frame_done (frame_done),
    .buf_int    (buf_int)
  );

  assign dt_rx = loopback ? dt_tx : slave_rx;

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Slave converter: counter cleared by a c4 rise in the guard slot, samples on even counts
  // and answers with the inverted bit, which the master picks up one slot later.
  always @(posedge c4) begin
    if (!f0) begin
      slv_cnt = 0;
    end else begin
      if (slv_cnt[0] == 1'b0 && slv_cnt < 64) begin
        slv_word = {dt_tx, slv_word[31:1]};
        slave_rx = ~dt_tx;
        if (slv_cnt == 62) begin
          checkOutput("slave_word_pending", {31'b0, exp_tx.size() > 0}, 32'd1);
          if (exp_tx.size() > 0) checkOutput("slave_word", slv_word, exp_tx.pop_front());
        end
      end
      slv_cnt++;
    end
  end

  always @(posedge clk50) cyc_cnt++;

  always @(negedge clk50) begin
    int e;
    if (frame_done) begin
      done_cnt++;
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc_cnt;
      checkOutput("frame_done_expected", {31'b0, frame_done}, {31'b0, exp_frame.size() > 0});
      if (exp_frame.size() > 0) begin
        e = exp_frame.pop_front();
        checkOutput("frame_idx_at_done", {29'b0, frame_idx}, e);
        checkOutput("buf_int_at_done", {31'b0, buf_int}, {31'b0, e == NUM_WORDS - 1});
      end
    end else if (buf_int) begin
      checkOutput("buf_int_with_done", {31'b0, frame_done}, {31'b0, buf_int});
    end
    if (buf_int) int_cnt++;
  end

  task automatic applyStimulus(input int addr, input logic [31:0] data);
    @(negedge clk50);
    bus.tx_wr_en   = 1'b1;
    bus.tx_wr_addr = AW'(addr);
    bus.tx_wr_data = data;
    tx_model[addr] = data;
    @(negedge clk50);
    bus.tx_wr_en   = 1'b0;
  endtask

  task automatic readRx(input int addr, output logic [31:0] data);
    @(negedge clk50);
    bus.rx_rd_addr = AW'(addr);
    @(posedge clk50);
    #1 data = bus.rx_rd_data;
  endtask

  task automatic waitFrames(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < n * FRAME_LEN + 2000) begin
      @(negedge clk50);
      cyc++;
      if (frame_done) got++;
    end
    checkOutput("wait_frames", got, n);
  endtask

  task automatic waitIdle();
    int cyc = 0;
    while (busy && cyc < 2 * FRAME_LEN) begin
      @(negedge clk50);
      cyc++;
    end
    checkOutput("busy_cleared", {31'b0, busy}, 32'd0);
  endtask

  task automatic checkResetState();
    checkOutput("rst_c4", {31'b0, c4}, 32'd0);
    checkOutput("rst_f0", {31'b0, f0}, 32'd0);
    checkOutput("rst_dt_tx", {31'b0, dt_tx}, 32'd0);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_frame_idx", {29'b0, frame_idx}, 32'd0);
    checkOutput("rst_frame_done", {31'b0, frame_done}, 32'd0);
    checkOutput("rst_buf_int", {31'b0, buf_int}, 32'd0);
    checkOutput("rst_rx_rd_data", bus.rx_rd_data, 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        bad;
    int          lat;
    int          base;
    logic [31:0] new_word;

    checks = 0; errors = 0; done_cnt = 0; int_cnt = 0; cyc_cnt = 0;
    last_done_cyc = 0; prev_done_cyc = 0;
    slv_cnt = 0; slv_word = '0; slave_rx = 1'b0; loopback = 1'b0;
    reset = 1'b1; enable = 1'b0;
    bus.tx_wr_en = 1'b0; bus.tx_wr_addr = '0; bus.tx_wr_data = '0; bus.rx_rd_addr = '0;
    for (int i = 0; i < NUM_WORDS; i++) tx_model[i] = '0;

    repeat (3) @(posedge clk50);
    #1 checkResetState();
    @(negedge clk50) reset = 1'b0;

    $display("[TB] idle with enable low");
    bad = 1'b0;
    repeat (100) begin
      @(negedge clk50);
      bad = bad | c4 | f0 | dt_tx | busy | frame_done | buf_int;
    end
    checkOutput("idle_quiet", {31'b0, bad}, 32'd0);
    checkOutput("idle_no_pulses", done_cnt + int_cnt, 0);

    $display("[TB] loopback single frame");
    loopback = 1'b1;
    applyStimulus(0, 32'hA5A5_0F01);
    exp_tx.push_back(32'hA5A5_0F01);
    exp_frame.push_back(0);
    @(negedge clk50) enable = 1'b1;
    lat = 0;
    do begin
      @(posedge clk50);
      #1 lat++;
    end while (!c4 && lat < 50);
    checkOutput("first_c4_rise_latency", lat, C4_HALF + 1);
    checkOutput("busy_in_run", {31'b0, busy}, 32'd1);
    @(negedge clk50) enable = 1'b0;
    waitFrames(1);
    waitIdle();
    checkOutput("idx_after_idle", {29'b0, frame_idx}, 32'd0);
    readRx(0, rd);
    checkOutput("rx0_loopback", rd, 32'hA5A5_0F01);

    $display("[TB] slave model full buffer");
    loopback = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) applyStimulus(i, i * 32'h1111_1111);
    for (int i = 0; i < NUM_WORDS; i++) begin
      exp_tx.push_back(tx_model[i]);
      exp_frame.push_back(i);
    end
    base = int_cnt;
    @(negedge clk50) enable = 1'b1;
    waitFrames(7);
    checkOutput("frame_period", last_done_cyc - prev_done_cyc, FRAME_LEN);
    repeat (10) @(negedge clk50);
    enable = 1'b0;
    waitFrames(1);
    waitIdle();
    checkOutput("buf_int_once", int_cnt - base, 1);
    for (int i = 0; i < NUM_WORDS; i++) begin
      readRx(i, rd);
      checkOutput($sformatf("rx%0d_inverted", i), rd, ~(i * 32'h1111_1111));
    end

    $display("[TB] enable dropped mid frame 3");
    applyStimulus(3, 32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(tx_model[i]);
      exp_frame.push_back(i);
    end
    @(negedge clk50) enable = 1'b1;
    waitFrames(3);
    repeat (1 + 30 * SLOT_LEN) @(negedge clk50);
    enable = 1'b0;
    waitFrames(1);
    waitIdle();
    checkOutput("idx_after_drop", {29'b0, frame_idx}, 32'd0);
    readRx(3, rd);
    checkOutput("rx3_after_drop", rd, ~32'hDEAD_BEEF);
    repeat (200) @(negedge clk50);
    checkOutput("no_extra_frames", exp_frame.size(), 0);
    checkOutput("no_extra_words", exp_tx.size(), 0);

    $display("[TB] host write on slot 0 entry of frame 2");
    new_word = 32'h5A5A_C3C3;
    for (int f = 0; f < 11; f++) begin
      exp_tx.push_back((f == 10) ? new_word : tx_model[f % NUM_WORDS]);
      exp_frame.push_back(f % NUM_WORDS);
    end
    @(negedge clk50) enable = 1'b1;
    waitFrames(2);
    bus.tx_wr_en   = 1'b1;
    bus.tx_wr_addr = AW'(2);
    bus.tx_wr_data = new_word;
    @(negedge clk50);
    bus.tx_wr_en   = 1'b0;
    tx_model[2]    = new_word;
    waitFrames(8);
    repeat (10) @(negedge clk50);
    enable = 1'b0;
    waitFrames(1);
    waitIdle();
    readRx(2, rd);
    checkOutput("rx2_new_word", rd, ~new_word);

    $display("[TB] reset mid frame");
    applyStimulus(0, 32'h1234_5678);
    base = done_cnt;
    @(negedge clk50) enable = 1'b1;
    repeat (40 * SLOT_LEN + C4_HALF) @(negedge clk50);
    reset = 1'b1;
    @(posedge clk50);
    #1 checkResetState();
    @(negedge clk50);
    reset  = 1'b0;
    enable = 1'b0;
    repeat (FRAME_LEN + 20) @(negedge clk50);
    checkOutput("no_done_after_reset", done_cnt, base);
    readRx(0, rd);
    checkOutput("rx0_unchanged", rd, ~32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
